// File: rtl/control_unit_pkg.sv
// ============================================================================
// control_unit_pkg : widths, instruction field positions and opcodes
// Revision: 1.0
// ============================================================================
`default_nettype none

package control_unit_pkg;

  localparam int UNDEFINED     = 3;
  localparam int CNTR_WIDTH    = 8;
  localparam int ADDR_WIDTH    = 5;
  localparam int REG_BIT_CNT   = 3;
  localparam int DATA_WIDTH    = 8;
  localparam int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH;

  // Instruction word layout: {opcode, reserved, operand}
  localparam int OPND_LSB = 0;
  localparam int OPND_MSB = DATA_WIDTH - 1;
  localparam int RSV_LSB  = DATA_WIDTH;
  localparam int RSV_MSB  = DATA_WIDTH + UNDEFINED - 1;
  localparam int OPC_LSB  = DATA_WIDTH + UNDEFINED;
  localparam int OPC_MSB  = COMBINED_DATA - 1;

  localparam logic [ADDR_WIDTH-1:0] OP_NOP  = 5'd0;
  localparam logic [ADDR_WIDTH-1:0] OP_XOR  = 5'd1;
  localparam logic [ADDR_WIDTH-1:0] OP_OR   = 5'd2;
  localparam logic [ADDR_WIDTH-1:0] OP_AND  = 5'd3;
  localparam logic [ADDR_WIDTH-1:0] OP_SUBR = 5'd4;
  localparam logic [ADDR_WIDTH-1:0] OP_ADDR = 5'd5;
  localparam logic [ADDR_WIDTH-1:0] OP_RR   = 5'd6;
  localparam logic [ADDR_WIDTH-1:0] OP_RL   = 5'd7;
  localparam logic [ADDR_WIDTH-1:0] OP_DEC  = 5'd8;
  localparam logic [ADDR_WIDTH-1:0] OP_INC  = 5'd9;
  localparam logic [ADDR_WIDTH-1:0] OP_NOT  = 5'd10;
  localparam logic [ADDR_WIDTH-1:0] OP_SUBI = 5'd11;
  localparam logic [ADDR_WIDTH-1:0] OP_ADDI = 5'd12;
  localparam logic [ADDR_WIDTH-1:0] OP_LDI  = 5'd13;
  localparam logic [ADDR_WIDTH-1:0] OP_LDR  = 5'd14;
  localparam logic [ADDR_WIDTH-1:0] OP_STR  = 5'd15;
  localparam logic [ADDR_WIDTH-1:0] OP_JMP  = 5'd16;
  localparam logic [ADDR_WIDTH-1:0] OP_JZ   = 5'd17;
  localparam logic [ADDR_WIDTH-1:0] OP_JNZ  = 5'd18;
  localparam logic [ADDR_WIDTH-1:0] OP_JGZ  = 5'd19;
  localparam logic [ADDR_WIDTH-1:0] OP_HLT  = 5'd20;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_ZERO   = 2'd1,
    COND_NZERO  = 2'd2,
    COND_GRZ    = 2'd3
  } jump_cond_e;

endpackage

`default_nettype wire

// File: rtl/control_unit_instr_decode.sv
// ============================================================================
// control_unit_instr_decode : opcode -> instruction class flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_unit_instr_decode
  import control_unit_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] opcode,
  output logic                  is_alu,
  output logic                  is_imm,
  output logic                  is_store,
  output logic                  is_jump,
  output logic [1:0]            jump_cond,
  output logic                  is_halt,
  output logic                  is_known
);

  always_comb begin
    is_alu    = 1'b0;
    is_imm    = 1'b0;
    is_store  = 1'b0;
    is_jump   = 1'b0;
    jump_cond = COND_ALWAYS;
    is_halt   = 1'b0;
    is_known  = 1'b1;
    case (opcode)
      OP_NOP, OP_RR, OP_RL, OP_DEC, OP_INC, OP_NOT,
      OP_SUBI, OP_ADDI, OP_LDI: begin
        is_alu = 1'b1;
        is_imm = 1'b1;
      end
      OP_XOR, OP_OR, OP_AND, OP_SUBR, OP_ADDR, OP_LDR: begin
        is_alu = 1'b1;
      end
      OP_STR: is_store = 1'b1;
      OP_JMP: is_jump = 1'b1;
      OP_JZ: begin
        is_jump   = 1'b1;
        jump_cond = COND_ZERO;
      end
      OP_JNZ: begin
        is_jump   = 1'b1;
        jump_cond = COND_NZERO;
      end
      OP_JGZ: begin
        is_jump   = 1'b1;
        jump_cond = COND_GRZ;
      end
      OP_HLT: is_halt = 1'b1;
      default: begin
        // Unknown opcodes run as NOP through the ALU
        is_alu   = 1'b1;
        is_imm   = 1'b1;
        is_known = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/control_unit.sv
// ============================================================================
// control_unit : 3-cycle fetch/decode/execute sequencer driving an external ALU
// Revision: 1.0
// ============================================================================
`default_nettype none

module control_unit
  import control_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [CNTR_WIDTH-1:0]    instr_addr,
  input  logic [COMBINED_DATA-1:0] instr_data,
  output logic [REG_BIT_CNT-1:0]   reg_raddr,
  input  logic [DATA_WIDTH-1:0]    reg_rdata,
  output logic [REG_BIT_CNT-1:0]   reg_waddr,
  output logic [DATA_WIDTH-1:0]    reg_wdata,
  output logic                     reg_we,
  output logic [ADDR_WIDTH-1:0]    alu_op,
  output logic [DATA_WIDTH-1:0]    alu_in1,
  output logic [DATA_WIDTH-1:0]    alu_in2,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     alu_zero,
  input  logic                     alu_gr_z,
  output logic                     halted
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_EXECUTE = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  localparam int IR_WIDTH = ADDR_WIDTH + DATA_WIDTH;

  state_e                  state_q, state_d;
  logic [CNTR_WIDTH-1:0]   pc_q, pc_d;
  // Reserved bits are never consulted, so the IR keeps only opcode and operand
  logic [IR_WIDTH-1:0]     ir_q, ir_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    zero_q, zero_d;
  logic                    gr_z_q, gr_z_d;

  logic [ADDR_WIDTH-1:0]   ir_opcode;
  logic [DATA_WIDTH-1:0]   ir_operand;
  logic                    dec_alu, dec_imm, dec_store, dec_jump, dec_halt, dec_known;
  logic [1:0]              dec_cond;
  logic                    take_jump;
  logic                    unused_rsv;

  assign ir_opcode  = ir_q[IR_WIDTH-1 -: ADDR_WIDTH];
  assign ir_operand = ir_q[DATA_WIDTH-1:0];
  assign unused_rsv = ^instr_data[RSV_MSB:RSV_LSB];

  control_unit_instr_decode u_decode (
    .opcode    (ir_opcode),
    .is_alu    (dec_alu),
    .is_imm    (dec_imm),
    .is_store  (dec_store),
    .is_jump   (dec_jump),
    .jump_cond (dec_cond),
    .is_halt   (dec_halt),
    .is_known  (dec_known)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      gr_z_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      gr_z_q  <= gr_z_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    zero_d    = zero_q;
    gr_z_d    = gr_z_q;
    alu_op    = OP_NOP;
    reg_we    = 1'b0;
    take_jump = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = {instr_data[OPC_MSB:OPC_LSB], instr_data[OPND_MSB:OPND_LSB]};
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        state_d = S_FETCH;
        alu_op  = dec_known ? ir_opcode : OP_NOP;
        if (dec_alu) begin
          acc_d  = alu_result;
          zero_d = alu_zero;
          gr_z_d = alu_gr_z;
          pc_d   = pc_q + CNTR_WIDTH'(1);
        end else if (dec_store) begin
          reg_we = 1'b1;
          pc_d   = pc_q + CNTR_WIDTH'(1);
        end else if (dec_jump) begin
          case (dec_cond)
            COND_ZERO:  take_jump = zero_q;
            COND_NZERO: take_jump = !zero_q;
            COND_GRZ:   take_jump = gr_z_q;
            default:    take_jump = 1'b1;
          endcase
          pc_d = take_jump ? ir_operand[CNTR_WIDTH-1:0] : pc_q + CNTR_WIDTH'(1);
        end else if (dec_halt) begin
          state_d = S_HALT;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Register read is issued during DECODE straight from the ROM word
  assign reg_raddr  = (state_q == S_DECODE) ? instr_data[REG_BIT_CNT-1:0]
                                            : ir_operand[REG_BIT_CNT-1:0];
  assign reg_waddr  = ir_operand[REG_BIT_CNT-1:0];
  assign reg_wdata  = acc_q;
  assign instr_addr = pc_q;
  assign alu_in1    = acc_q;
  assign alu_in2    = (state_q == S_EXECUTE && !dec_imm) ? reg_rdata : ir_operand;
  assign halted     = (state_q == S_HALT);

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// ============================================================================
// tb_control_unit : directed + randomized checks against an ISA-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_control_unit;
  import control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  instr_addr;
  logic [15:0] instr_data = '0;
  logic [2:0]  reg_raddr, reg_waddr;
  logic [7:0]  reg_rdata = '0;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic [4:0]  alu_op;
  logic [7:0]  alu_in1, alu_in2, alu_result;
  logic        alu_zero, alu_gr_z, halted;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom [256];
  logic [7:0]  rf  [8] = '{default: 8'h00};

  logic [7:0]  m_pc, m_acc;
  logic        m_z, m_gz, m_halt;
  logic [7:0]  m_regs [8];

  control_unit dut (
    .clk(clk), .rst_n(rst_n),
    .instr_addr(instr_addr), .instr_data(instr_data),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_gr_z(alu_gr_z),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(logic [4:0] op, logic [7:0] a, logic [7:0] b);
    case (op)
      OP_XOR:          return a ^ b;
      OP_OR:           return a | b;
      OP_AND:          return a & b;
      OP_SUBR, OP_SUBI: return a - b;
      OP_ADDR, OP_ADDI: return a + b;
      OP_RR:           return {a[0], a[7:1]};
      OP_RL:           return {a[6:0], a[7]};
      OP_DEC:          return a - 8'd1;
      OP_INC:          return a + 8'd1;
      OP_NOT:          return ~a;
      OP_LDI, OP_LDR:  return b;
      default:         return a;
    endcase
  endfunction

  function automatic logic gz_fn(logic [7:0] r);
    return (r != 8'd0) && !r[7];
  endfunction

  function automatic logic is_rform(logic [4:0] op);
    return op inside {OP_XOR, OP_OR, OP_AND, OP_SUBR, OP_ADDR, OP_LDR};
  endfunction

  // External ALU, synchronous ROM and register file stand-ins
  assign alu_result = alu_fn(alu_op, alu_in1, alu_in2);
  assign alu_zero   = (alu_result == 8'd0);
  assign alu_gr_z   = gz_fn(alu_result);

  always @(posedge clk) begin
    instr_data <= rom[instr_addr];
    if (reg_we) rf[reg_waddr] <= reg_wdata;
    reg_rdata <= rf[reg_raddr];
  end

  function automatic logic [15:0] mk(logic [4:0] op, logic [7:0] opnd);
    logic [2:0] rsv;
    rsv = 3'($urandom);
    return {op, rsv, opnd};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = mk(OP_NOP, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    m_pc = 0; m_acc = 0; m_z = 0; m_gz = 0; m_halt = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = rf[i];
    rst_n = 1'b1;
  endtask

  // ISA-level reference: one whole instruction per call
  task automatic model_step(output logic was_store);
    logic [15:0] w;
    logic [4:0]  op;
    logic [7:0]  opnd, b, r;
    w = rom[m_pc]; op = w[15:11]; opnd = w[7:0];
    was_store = 1'b0;
    case (op)
      OP_STR: begin m_regs[opnd[2:0]] = m_acc; m_pc = m_pc + 1; was_store = 1'b1; end
      OP_JMP: m_pc = opnd;
      OP_JZ:  m_pc = m_z  ? opnd : m_pc + 1;
      OP_JNZ: m_pc = !m_z ? opnd : m_pc + 1;
      OP_JGZ: m_pc = m_gz ? opnd : m_pc + 1;
      OP_HLT: m_halt = 1'b1;
      default: begin
        b = is_rform(op) ? m_regs[opnd[2:0]] : opnd;
        r = (op <= OP_LDR) ? alu_fn(op, m_acc, b) : m_acc;
        m_acc = r; m_z = (r == 0); m_gz = gz_fn(r);
        m_pc = m_pc + 1;
      end
    endcase
  endtask

  // Runs one 3-cycle instruction from a FETCH negedge and records what the DUT showed
  task automatic exec_instr(output logic [7:0] f_addr, output int we_cnt,
                            output logic [2:0] waddr, output logic [7:0] wdata,
                            output logic [7:0] in2, output logic [7:0] rdata,
                            output logic [7:0] acc_after, output logic [7:0] pc_after);
    f_addr = instr_addr;
    we_cnt = int'(reg_we);
    @(negedge clk);
    we_cnt += int'(reg_we);
    @(negedge clk);
    we_cnt += int'(reg_we);
    waddr = reg_waddr; wdata = reg_wdata; in2 = alu_in2; rdata = reg_rdata;
    @(negedge clk);
    acc_after = reg_wdata;
    pc_after  = instr_addr;
  endtask

  logic [7:0] o_f, o_wd, o_in2, o_rd, o_acc, o_pc;
  logic [2:0] o_wa;
  int         o_we;

  task automatic test_reset();
    clear_rom();
    rom[0] = mk(OP_ADDI, 8'h1D);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if (instr_addr !== 8'd0 || halted !== 1'b0 || reg_we !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs addr=%h halted=%b we=%b required 00/0/0", instr_addr, halted, reg_we); end
    n_checks++; if (reg_wdata !== 8'd0 || $isunknown({alu_in1, alu_in2})) begin
      n_fail++; $display("FAIL reset_datapath acc=%h in1=%h in2=%h required acc=00 and no X", reg_wdata, alu_in1, alu_in2); end
    do_reset();
    n_checks++; if (alu_op !== OP_NOP || instr_addr !== 8'd0) begin
      n_fail++; $display("FAIL first_fetch op=%0d addr=%h required op=0 addr=00", alu_op, instr_addr); end
    @(negedge clk);
    n_checks++; if (alu_op !== OP_NOP || reg_raddr !== 3'd5) begin
      n_fail++; $display("FAIL first_decode op=%0d raddr=%0d required op=0 raddr=5", alu_op, reg_raddr); end
    @(negedge clk);
    n_checks++; if (alu_op !== OP_ADDI || alu_in2 !== 8'h1D) begin
      n_fail++; $display("FAIL first_execute op=%0d in2=%h required op=%0d in2=1d", alu_op, alu_in2, OP_ADDI); end
  endtask

  task automatic test_imm_arith();
    logic [7:0] exp_acc [3];
    exp_acc = '{8'd5, 8'd8, 8'd0};
    clear_rom();
    rom[0] = mk(OP_LDI, 8'd5); rom[1] = mk(OP_ADDI, 8'd3); rom[2] = mk(OP_SUBI, 8'd8);
    rom[3] = mk(OP_JZ, 8'd7);  rom[7] = mk(OP_HLT, 8'd0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
      n_checks++; if (o_acc !== exp_acc[i] || o_f !== 8'(i) || o_pc !== 8'(i + 1)) begin
        n_fail++; $display("FAIL imm_arith[%0d] acc=%h fetch=%h pc=%h required acc=%h fetch=%h pc=%h",
                           i, o_acc, o_f, o_pc, exp_acc[i], 8'(i), 8'(i + 1)); end
    end
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_pc !== 8'd7) begin
      n_fail++; $display("FAIL imm_zero_flag pc=%h required 07", o_pc); end
  endtask

  task automatic test_register_path();
    clear_rom();
    rom[0] = mk(OP_LDI, 8'h2A); rom[1] = mk(OP_STR, 8'h1B);
    rom[2] = mk(OP_LDI, 8'h00); rom[3] = mk(OP_LDR, 8'hF3);
    do_reset();
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_we !== 0) begin n_fail++; $display("FAIL reg_ldi_we count=%0d required 0", o_we); end
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_we !== 1 || o_wa !== 3'd3 || o_wd !== 8'h2A || o_acc !== 8'h2A) begin
      n_fail++; $display("FAIL reg_store we=%0d waddr=%0d wdata=%h acc=%h required 1/3/2a/2a", o_we, o_wa, o_wd, o_acc); end
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_acc !== 8'h00 || o_we !== 0) begin
      n_fail++; $display("FAIL reg_clear acc=%h we=%0d required 00/0", o_acc, o_we); end
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_in2 !== o_rd || o_in2 !== 8'h2A || o_acc !== 8'h2A) begin
      n_fail++; $display("FAIL reg_load in2=%h rdata=%h acc=%h required 2a/2a/2a", o_in2, o_rd, o_acc); end
  endtask

  task automatic test_cond_jumps();
    logic [4:0] first_op [4], jop [4];
    logic [7:0] first_v [4], exp_pc [4];
    first_op = '{OP_LDI, OP_LDI, OP_LDI, OP_LDI};
    first_v  = '{8'd1, 8'd2, 8'd0, 8'd2};
    jop      = '{OP_JZ, OP_JZ, OP_JGZ, OP_JNZ};
    exp_pc   = '{8'd10, 8'd3, 8'd20, 8'd40};
    for (int t = 0; t < 4; t++) begin
      clear_rom();
      rom[0] = mk(first_op[t], first_v[t]);
      rom[1] = mk((t == 2) ? OP_INC : OP_DEC, 8'h00);
      rom[2] = mk(jop[t], (t == 0) ? 8'd10 : (t == 2) ? 8'd20 : (t == 3) ? 8'd40 : 8'd10);
      do_reset();
      repeat (3) exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
      n_checks++; if (o_pc !== exp_pc[t]) begin
        n_fail++; $display("FAIL cond_jump[%0d] pc=%0d required %0d", t, o_pc, exp_pc[t]); end
    end
  endtask

  task automatic test_wrap_halt();
    clear_rom();
    rom[0] = mk(OP_JMP, 8'hFF); rom[255] = mk(OP_NOP, 8'h00);
    do_reset();
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_jmp pc=%h required ff", o_pc); end
    rom[0] = mk(OP_HLT, 8'h00);
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_f !== 8'hFF || o_pc !== 8'h00) begin
      n_fail++; $display("FAIL wrap_inc fetch=%h pc=%h required ff/00", o_f, o_pc); end
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    for (int i = 0; i < 22; i++) begin
      n_checks++; if (halted !== 1'b1 || reg_we !== 1'b0 || alu_op !== OP_NOP || instr_addr !== 8'h00) begin
        n_fail++; $display("FAIL halt_hold[%0d] halted=%b we=%b op=%0d pc=%h required 1/0/0/00",
                           i, halted, reg_we, alu_op, instr_addr); end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] r4_before;
    clear_rom();
    rom[0] = mk(OP_LDI, 8'h55); rom[1] = mk(OP_STR, 8'h04);
    do_reset();
    r4_before = rf[4];
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (reg_we !== 1'b1) begin n_fail++; $display("FAIL areset_pre we=%b required 1", reg_we); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (reg_we !== 1'b0 || reg_wdata !== 8'h00 || instr_addr !== 8'h00) begin
      n_fail++; $display("FAIL areset_drop we=%b acc=%h pc=%h required 0/00/00", reg_we, reg_wdata, instr_addr); end
    do_reset();
    n_checks++; if (rf[4] !== r4_before) begin
      n_fail++; $display("FAIL areset_nowrite r4=%h required %h", rf[4], r4_before); end
    exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
    n_checks++; if (o_f !== 8'h00 || o_acc !== 8'h55) begin
      n_fail++; $display("FAIL areset_restart fetch=%h acc=%h required 00/55", o_f, o_acc); end
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [7:0] exp_f, exp_acc;
    logic       st;
    for (int i = 0; i < 256; i++) begin
      op = 5'($urandom_range(0, 23));
      if (op == OP_HLT) op = OP_NOP;
      if (op > OP_HLT) op = 5'($urandom_range(21, 31));
      rom[i] = mk(op, 8'($urandom));
    end
    do_reset();
    for (int k = 0; k < 120; k++) begin
      exp_f = m_pc;
      exp_acc = m_acc;
      model_step(st);
      exec_instr(o_f, o_we, o_wa, o_wd, o_in2, o_rd, o_acc, o_pc);
      n_checks++; if (o_f !== exp_f || o_pc !== m_pc || o_acc !== m_acc) begin
        n_fail++; $display("FAIL random[%0d] fetch=%h pc=%h acc=%h required %h/%h/%h",
                           k, o_f, o_pc, o_acc, exp_f, m_pc, m_acc); end
      n_checks++; if (o_we !== int'(st) || (st && (o_wa !== rom[exp_f][2:0] || o_wd !== exp_acc))) begin
        n_fail++; $display("FAIL random_store[%0d] we=%0d waddr=%0d wdata=%h required we=%0d waddr=%0d wdata=%h",
                           k, o_we, o_wa, o_wd, st, rom[exp_f][2:0], exp_acc); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_imm_arith();
    test_register_path();
    test_cond_jumps();
    test_wrap_halt();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
